// File: rtl/mul_tree_out_packer.sv
// Result-stream receiver: buffers multiplier-tree words per batch,
// rescales bf16 lanes to the batch maximum and packs 4 words per beat.
module mul_tree_out_packer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       mul_out,
    input  logic              mul_out_vld,
    input  logic [ADDR_W:0]   batch_words,
    input  logic [7:0]        max_exponent,
    input  logic              max_exponent_vld,
    output logic              max_exponent_ready,
    output logic [255:0]      pkt_data,
    output logic              pkt_vld,
    input  logic              pkt_ready,
    output logic              busy,
    output logic              err_overflow
);

    typedef enum logic [1:0] {IDLE, ASM, HOLD} state_t;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W-2:0] BEAT_ONE = 1;

    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wptr, rptr;
    logic [ADDR_W:0]   count, wcnt;
    logic              cap_pend;
    logic [7:0]        eq [2];
    logic              eq_wp, eq_rp;
    logic [1:0]        eq_cnt;
    state_t            state, state_nx;
    logic [1:0]        lane_j;
    logic [7:0]        m_lat;
    logic [ADDR_W-2:0] beats;
    logic [63:0]       stage [4];
    logic [63:0]       nword;

    logic fifo_empty, fifo_full, last_word;
    logic pop, wr_ok, wr_drop;
    logic capture, load, eq_pop, eq_push, eq_drop, start;

    function automatic logic [15:0] norm(input logic [15:0] l,
                                         input logic [7:0]  m);
        logic [9:0] ne;
        ne = {2'b00, l[14:7]} + 10'd127 - {2'b00, m};
        if (l[14:7] == 8'h00)
            norm = {l[15], 15'h0};
        else if (l[14:7] == 8'hFF)
            norm = l;
        else if (ne[9] || ne == 10'd0)
            norm = {l[15], 15'h0};
        else if (ne >= 10'd255)
            norm = {l[15], 8'd254, l[6:0]};
        else
            norm = {l[15], ne[7:0], l[6:0]};
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign last_word  = (wcnt == batch_words - CNT_ONE);
    assign pop        = (state == ASM) && !fifo_empty;
    assign wr_ok      = mul_out_vld && (!fifo_full || pop);
    assign wr_drop    = mul_out_vld && fifo_full && !pop;

    assign max_exponent_ready = !rst && mul_out_vld && last_word;

    assign capture = cap_pend && max_exponent_vld;
    assign load    = (state == HOLD) && (!pkt_vld || pkt_ready);
    assign eq_pop  = load && (beats == BEAT_ONE);
    assign eq_push = capture && (eq_cnt != 2'd2 || eq_pop);
    assign eq_drop = capture && (eq_cnt == 2'd2) && !eq_pop;
    assign start   = (state == IDLE) && (eq_cnt != 2'd0);

    assign busy = !fifo_empty || (eq_cnt != 2'd0) || pkt_vld;

    always_comb begin
        nword = '0;
        for (int k = 0; k < 4; k++)
            nword[16*k +: 16] = norm(mem[rptr][16*k +: 16], m_lat);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = ASM;
            ASM:  if (pop && lane_j == 2'd3) state_nx = HOLD;
            HOLD: if (load) state_nx = (beats == BEAT_ONE) ? IDLE : ASM;
            default: state_nx = IDLE;
        endcase
    end

    // Storage arrays carry no reset; pointers and counts qualify them.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= mul_out;
        if (eq_push) eq[eq_wp] <= max_exponent;
        if (pop) stage[lane_j] <= nword;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            wcnt         <= '0;
            cap_pend     <= 1'b0;
            eq_wp        <= 1'b0;
            eq_rp        <= 1'b0;
            eq_cnt       <= 2'd0;
            state        <= IDLE;
            lane_j       <= 2'd0;
            m_lat        <= 8'd0;
            beats        <= '0;
            pkt_data     <= '0;
            pkt_vld      <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (wr_ok) wptr <= wptr + PTR_ONE;
            if (pop)   rptr <= rptr + PTR_ONE;
            case ({wr_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (mul_out_vld)
                wcnt <= last_word ? '0 : wcnt + CNT_ONE;
            if (mul_out_vld && last_word)
                cap_pend <= 1'b1;
            else if (capture)
                cap_pend <= 1'b0;
            if (wr_drop || eq_drop)
                err_overflow <= 1'b1;
            if (eq_push) eq_wp <= ~eq_wp;
            if (eq_pop)  eq_rp <= ~eq_rp;
            case ({eq_push, eq_pop})
                2'b10:   eq_cnt <= eq_cnt + 2'd1;
                2'b01:   eq_cnt <= eq_cnt - 2'd1;
                default: eq_cnt <= eq_cnt;
            endcase
            if (start) begin
                m_lat  <= eq[eq_rp];
                beats  <= batch_words[ADDR_W:2];
                lane_j <= 2'd0;
            end else if (pop) begin
                lane_j <= lane_j + 2'd1;
            end
            if (load) begin
                pkt_data <= {stage[3], stage[2], stage[1], stage[0]};
                pkt_vld  <= 1'b1;
                beats    <= beats - BEAT_ONE;
            end else if (pkt_vld && pkt_ready) begin
                pkt_vld <= 1'b0;
            end
        end
    end

endmodule
